bcd_updown_counter: RTL and testbench
=====================================

# bcd_updown_counter

Multi-digit BCD up/down counter with built-in tick prescaler, synchronous clear and parallel load. It sits directly upstream of the per-digit seven-segment decoders in the counter design. Each 4-bit digit output drives one decoder's `number` input. Every digit is guaranteed to stay in 0–9, so the decoders never reach their blank/default code during normal counting.

## Interface
- `DIGITS`, default 4: number of BCD digits; legal values 1–8.
- `TICK_DIV`, default 50_000_000: `clk` cycles per count step while enabled; must be ≥1.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_N`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run enable; prescaler and counting advance only while high.
- `up`  in  1  direction: 1 = increment, 0 = decrement; sampled at the tick cycle.
- `clr`  in  1  synchronous clear of digits and prescaler.
- `load`  in  1  synchronous parallel load of `load_val`.
- `load_val`  in  4*DIGITS  BCD load value; digit i at bits [4i+3:4i], digit 0 = least significant.
- `digits`  out  4*DIGITS  registered BCD count, same packing as `load_val`.
- `tick`  out  1  one-cycle pulse on each count step.
- `wrap`  out  1  one-cycle pulse when the count wraps (all-9s→0 up, 0→all-9s down).
- `load_err`  out  1  one-cycle pulse when a loaded digit was >9.
- `zero`  out  1  high while `digits` is all zeros.

## Operation
- Reset (`rst_N`=0): `digits`=0, prescaler=0; `tick`, `wrap` and `load_err` = 0; `zero`=1.
- Priority each cycle: `clr` > `load` > count step > hold.
- `clr`: `digits`←0, prescaler←0, no `tick` or `wrap`.
- `load`: each digit ←`load_val` digit. A digit >9 is clamped to 9; `load_err`=1 next cycle if any digit was clamped. Prescaler←0. No `tick` or `wrap`.
- Prescaler: counts 0…`TICK_DIV`−1 while `en`=1, holds while `en`=0. At `TICK_DIV`−1 with `en`=1 it returns to 0 and a count step occurs.
- Up step: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. A carry out of the top digit sets `wrap`.
- Down step: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. A borrow out of the top digit sets `wrap`.
- Counting range is 0 … 10^DIGITS−1, modular in both directions.
- `up` changing mid-interval only affects the next step.
- `en` deasserted mid-interval: the prescaler freezes and resumes from the same value when `en` returns.

## Timing
- `digits`, `tick`, `wrap` and `load_err` are registered and update on the same edge. `tick` and `wrap` are high in the cycle in which the new count first appears.
- With `en` held high from a clear, the first step appears `TICK_DIV` cycles after `clr` deasserts. Later steps follow every `TICK_DIV` cycles.
- `TICK_DIV`=1: a step occurs every enabled cycle.
- `clr` or `load` in a tick cycle: the step is suppressed; `tick`=0 and `wrap`=0 on the following cycle.
- `zero` is decoded combinationally from the `digits` register.
- Asynchronous reset mid-interval or mid-carry discards all state immediately. Counting restarts from 0 after `rst_N` releases.
- Downstream decoder adds one further register stage, so display latency is 1 cycle after `digits`.

## Structure
- Shared package (`counter_pkg`): `bcd_t` (4-bit digit typedef), `BCD_MAX`=4'd9, `BCD_MIN`=4'd0.
- Sub-module `bcd_digit`: one registered digit.
  - Inputs: step, up, `clr`, `load`, `load_val` digit.
  - Outputs: value, carry/borrow.
  - The top level instantiates `DIGITS` copies via generate with a ripple carry chain, plus the prescaler and the output pulse registers.

## Test plan
Bench parameters: `DIGITS`=4, `TICK_DIV`=4.

1. Reset, then `en`=1, `up`=1 for 40 cycles → `digits`=0x0010 after the 10th `tick`. The 10th tick lands on cycle 40; ticks are exactly 4 cycles apart.
2. `load` 0x9998, `up`=1, run 2 ticks → 0x9999, then 0x0000. `wrap`=1 only on the second tick and `zero`=1.
3. `load` 0x0001, `up`=0, run 2 ticks → 0x0000, then 0x9999. `wrap`=1 on the second tick.
4. `load` 0x3AF2 → `digits`=0x3992 and a single-cycle `load_err`=1. Loading 0x1234 → `load_err`=0.
5. Assert `clr` and `load` together in a tick cycle → `digits`=0, `tick`=0, `wrap`=0, prescaler restarts at 0.
6. Drop `en` after 2 prescaler cycles for 10 cycles, then re-raise it → next `tick` 2 enabled cycles later. Separately, pulse `rst_N` low mid-count → `digits`=0 immediately, asynchronously.

Source files
------------

// File: rtl/bcd_updown_counter_pkg.sv
// counter_pkg: shared BCD digit type, limits and load clamp helper.
package counter_pkg;
   typedef logic [3:0] bcd_t;
   localparam bcd_t BCD_MAX = 4'd9;
   localparam bcd_t BCD_MIN = 4'd0;
   function automatic bcd_t bcd_clamp(bcd_t d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction
endpackage

// File: rtl/bcd_updown_counter_if.sv
// bcd_updown_counter_if: control inputs and BCD count outputs of the counter.
interface bcd_updown_counter_if #(parameter int DIGITS = 4);
   logic                  en;
   logic                  up;
   logic                  clr;
   logic                  load;
   logic [4*DIGITS-1:0]   load_val;
   logic [4*DIGITS-1:0]   digits;
   logic                  tick;
   logic                  wrap;
   logic                  load_err;
   logic                  zero;
   modport master (output en, up, clr, load, load_val, input digits, tick, wrap, load_err, zero);
   modport slave  (input en, up, clr, load, load_val, output digits, tick, wrap, load_err, zero);
endinterface

// File: rtl/bcd_updown_counter_digit.sv
// bcd_digit: one registered BCD digit with clear, clamped load and up/down step.
module bcd_digit
   import counter_pkg::*;
(
   input  logic clk,
   input  logic rst_N,
   input  logic step_i,
   input  logic up_i,
   input  logic clr_i,
   input  logic load_i,
   input  bcd_t load_val_i,
   output bcd_t value_o,
   output logic carry_o
);
   bcd_t value_q, value_d;
   logic at_edge;
   assign at_edge = up_i ? (value_q == BCD_MAX) : (value_q == BCD_MIN);
   assign carry_o = step_i && at_edge;
   always_comb begin
      value_d = clr_i  ? BCD_MIN :
                load_i ? bcd_clamp(load_val_i) :
                !step_i ? value_q :
                up_i   ? (at_edge ? BCD_MIN : value_q + 4'd1) :
                         (at_edge ? BCD_MAX : value_q - 4'd1);
   end
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) value_q <= BCD_MIN;
      else        value_q <= value_d;
   end
   assign value_o = value_q;
endmodule

// File: rtl/bcd_updown_counter.sv
// bcd_updown_counter: prescaled multi-digit BCD up/down counter with clear and load.
module bcd_updown_counter
   import counter_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int TICK_DIV = 50_000_000
)(
   input logic clk,
   input logic rst_N,
   bcd_updown_counter_if.slave bus
);
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
   logic [PW-1:0]       presc_q, presc_d;
   logic [DIGITS:0]     chain;
   logic [DIGITS-1:0]   bad;
   logic [4*DIGITS-1:0] digits_w;
   logic                tick_q, wrap_q, load_err_q;
   // clr and load both outrank the step, so the chain only starts when neither is active
   assign chain[0] = bus.en && (presc_q == LAST) && !bus.clr && !bus.load;
   assign presc_d  = (bus.clr || bus.load) ? '0 :
                     !bus.en              ? presc_q :
                     (presc_q == LAST)    ? '0 : presc_q + 1'b1;
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
         .clk        (clk),
         .rst_N      (rst_N),
         .step_i     (chain[g]),
         .up_i       (bus.up),
         .clr_i      (bus.clr),
         .load_i     (bus.load),
         .load_val_i (bus.load_val[4*g +: 4]),
         .value_o    (digits_w[4*g +: 4]),
         .carry_o    (chain[g+1])
      );
      assign bad[g] = bus.load_val[4*g +: 4] > BCD_MAX;
   end
   always_ff @(posedge clk or negedge rst_N) begin
      if (!rst_N) begin
         presc_q    <= '0;
         tick_q     <= 1'b0;
         wrap_q     <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         presc_q    <= presc_d;
         tick_q     <= chain[0];
         wrap_q     <= chain[DIGITS];
         load_err_q <= bus.load && !bus.clr && |bad;
      end
   end
   assign bus.digits   = digits_w;
   assign bus.tick     = tick_q;
   assign bus.wrap     = wrap_q;
   assign bus.load_err = load_err_q;
   assign bus.zero     = (digits_w == '0);
endmodule

// File: tb/tb_bcd_updown_counter.sv
// tb_bcd_updown_counter: directed scenario tasks for the BCD counter, DIGITS=4, TICK_DIV=4.
module tb_bcd_updown_counter;
   logic clk = 1'b0;
   logic rst_N = 1'b0;
   int checks = 0;
   int errors = 0;
   bcd_updown_counter_if #(.DIGITS(4)) bus ();
   bcd_updown_counter #(.DIGITS(4), .TICK_DIV(4)) dut (.clk(clk), .rst_N(rst_N), .bus(bus));
   always #5 clk = ~clk;

   task automatic wait_tick(output int n, output bit ok);
      n = 0;
      ok = 1'b0;
      for (int k = 0; k < 20 && !ok; k++) begin
         @(posedge clk); #1;
         n++;
         if (bus.tick === 1'b1) ok = 1'b1;
      end
   endtask

   task automatic do_load(input logic [15:0] v);
      bus.load = 1'b1;
      bus.load_val = v;
      @(posedge clk); #1;
      bus.load = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (bus.digits !== 16'h0000 || bus.zero !== 1'b1 || bus.tick !== 1'b0 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
         errors++;
         $display("FAIL reset: digits=%h zero=%b tick=%b wrap=%b load_err=%b, need 0000 1 0 0 0", bus.digits, bus.zero, bus.tick, bus.wrap, bus.load_err);
      end
      @(negedge clk);
      rst_N = 1'b1;
   endtask

   task automatic test_count_up();
      int ticks = 0;
      @(posedge clk); #1;
      bus.en = 1'b1;
      bus.up = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus.tick !== (i % 4 == 3)) begin
            errors++;
            $display("FAIL tick_spacing cycle %0d: tick=%b need %b", i + 1, bus.tick, (i % 4 == 3));
         end
         if (bus.tick === 1'b1) ticks++;
      end
      checks++;
      if (bus.digits !== 16'h0010 || ticks != 10) begin
         errors++;
         $display("FAIL count_up: digits=%h ticks=%0d, need 0010 10", bus.digits, ticks);
      end
   endtask

   task automatic test_wrap_up();
      int n;
      bit ok;
      bus.up = 1'b1;
      do_load(16'h9998);
      wait_tick(n, ok);
      checks++;
      if (!ok || bus.digits !== 16'h9999 || bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap_up_1: ok=%b digits=%h wrap=%b, need 1 9999 0", ok, bus.digits, bus.wrap);
      end
      wait_tick(n, ok);
      checks++;
      if (!ok || bus.digits !== 16'h0000 || bus.wrap !== 1'b1 || bus.zero !== 1'b1) begin
         errors++;
         $display("FAIL wrap_up_2: ok=%b digits=%h wrap=%b zero=%b, need 1 0000 1 1", ok, bus.digits, bus.wrap, bus.zero);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.wrap !== 1'b0) begin
         errors++;
         $display("FAIL wrap_pulse: wrap=%b need 0", bus.wrap);
      end
   endtask

   task automatic test_wrap_down();
      int n;
      bit ok;
      bus.up = 1'b0;
      do_load(16'h0001);
      wait_tick(n, ok);
      checks++;
      if (!ok || bus.digits !== 16'h0000 || bus.wrap !== 1'b0 || bus.zero !== 1'b1) begin
         errors++;
         $display("FAIL wrap_down_1: ok=%b digits=%h wrap=%b zero=%b, need 1 0000 0 1", ok, bus.digits, bus.wrap, bus.zero);
      end
      wait_tick(n, ok);
      checks++;
      if (!ok || bus.digits !== 16'h9999 || bus.wrap !== 1'b1 || bus.zero !== 1'b0) begin
         errors++;
         $display("FAIL wrap_down_2: ok=%b digits=%h wrap=%b zero=%b, need 1 9999 1 0", ok, bus.digits, bus.wrap, bus.zero);
      end
   endtask

   task automatic test_load_clamp();
      do_load(16'h3AF2);
      checks++;
      if (bus.digits !== 16'h3992 || bus.load_err !== 1'b1) begin
         errors++;
         $display("FAIL load_clamp: digits=%h load_err=%b, need 3992 1", bus.digits, bus.load_err);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.load_err !== 1'b0) begin
         errors++;
         $display("FAIL load_err_pulse: load_err=%b need 0", bus.load_err);
      end
      do_load(16'h1234);
      checks++;
      if (bus.digits !== 16'h1234 || bus.load_err !== 1'b0) begin
         errors++;
         $display("FAIL load_ok: digits=%h load_err=%b, need 1234 0", bus.digits, bus.load_err);
      end
   endtask

   task automatic test_clr_load_tick();
      int n;
      bit ok;
      bus.up = 1'b1;
      do_load(16'h0457);
      repeat (3) begin @(posedge clk); #1; end
      bus.clr = 1'b1;
      bus.load = 1'b1;
      bus.load_val = 16'h5555;
      @(posedge clk); #1;
      bus.clr = 1'b0;
      bus.load = 1'b0;
      checks++;
      if (bus.digits !== 16'h0000 || bus.tick !== 1'b0 || bus.wrap !== 1'b0 || bus.load_err !== 1'b0) begin
         errors++;
         $display("FAIL clr_in_tick: digits=%h tick=%b wrap=%b load_err=%b, need 0000 0 0 0", bus.digits, bus.tick, bus.wrap, bus.load_err);
      end
      wait_tick(n, ok);
      checks++;
      if (!ok || n != 4 || bus.digits !== 16'h0001) begin
         errors++;
         $display("FAIL presc_restart: ok=%b cycles=%0d digits=%h, need 1 4 0001", ok, n, bus.digits);
      end
   endtask

   task automatic test_en_pause();
      int n;
      int stray = 0;
      bit ok;
      repeat (2) begin @(posedge clk); #1; end
      bus.en = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (bus.tick !== 1'b0) stray++;
      end
      checks++;
      if (stray != 0 || bus.digits !== 16'h0001) begin
         errors++;
         $display("FAIL en_hold: stray ticks=%0d digits=%h, need 0 0001", stray, bus.digits);
      end
      bus.en = 1'b1;
      wait_tick(n, ok);
      checks++;
      if (!ok || n != 2 || bus.digits !== 16'h0002) begin
         errors++;
         $display("FAIL en_resume: ok=%b cycles=%0d digits=%h, need 1 2 0002", ok, n, bus.digits);
      end
   endtask

   task automatic test_async_reset();
      int n;
      bit ok;
      @(posedge clk); #3;
      rst_N = 1'b0;
      #1;
      checks++;
      if (bus.digits !== 16'h0000 || bus.zero !== 1'b1 || bus.tick !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: digits=%h zero=%b tick=%b, need 0000 1 0", bus.digits, bus.zero, bus.tick);
      end
      @(negedge clk);
      rst_N = 1'b1;
      wait_tick(n, ok);
      checks++;
      if (!ok || n != 4 || bus.digits !== 16'h0001) begin
         errors++;
         $display("FAIL reset_restart: ok=%b cycles=%0d digits=%h, need 1 4 0001", ok, n, bus.digits);
      end
   endtask

   initial begin
      bus.en = 1'b0;
      bus.up = 1'b1;
      bus.clr = 1'b0;
      bus.load = 1'b0;
      bus.load_val = '0;
      test_reset();
      test_count_up();
      test_wrap_up();
      test_wrap_down();
      test_load_clamp();
      test_clr_load_tick();
      test_en_pause();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
